// File: rtl/ps2_cmd_sequencer.sv
// PS/2 host command sequencer. Runs the keyboard reset/BAT handshake and the
// LED update (0xED + mask) exchange, retries on RESEND or timeout, and shares
// the receive byte stream: command responses are consumed while a sequence is
// in flight, and every byte received in READY or ERROR goes to the key decoder.
// Handshake: tx_start is a one-cycle request and tx_data is held until the tx
// engine answers with tx_done_tick; rx_done_tick marks rx_data valid for one
// cycle; key_valid marks key_code for one cycle, with key_code held after it.
module ps2_cmd_sequencer #(
  parameter int ACK_TIMEOUT = 2_000_000,
  parameter int BAT_TIMEOUT = 100_000_000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_req,
  input  logic       led_req,
  input  logic [2:0] led_mask,
  input  logic       tx_done_tick,
  input  logic       rx_done_tick,
  input  logic [7:0] rx_data,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       busy,
  output logic       ready,
  output logic       error
);

  localparam int RW = (MAX_RETRY > 1) ? $clog2(MAX_RETRY) : 1;
  localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRY - 1);
  localparam logic [31:0]   ACK_LAST   = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0]   BAT_LAST   = 32'(BAT_TIMEOUT - 1);

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    S_SEND_RST, S_SEND_ED, S_SEND_MASK, S_WAIT_TX,
    S_WAIT_ACK, S_WAIT_BAT, S_READY, S_ERROR
  } state_t;

  // Which command byte is in flight; selects the ACK successor and the resend target.
  typedef enum logic [1:0] { CMD_RST, CMD_ED, CMD_MASK } cmd_t;

  state_t          state_q, state_d, resend_state;
  cmd_t            cmd_q, cmd_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [31:0]     timer_q, timer_d;
  logic [2:0]      mask_q, mask_d;
  logic            led_pending_q, led_pending_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            key_valid_q, key_valid_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            retry_exhausted;

  assign busy            = (state_q != S_READY) && (state_q != S_ERROR);
  assign ready           = (state_q == S_READY);
  assign error           = (state_q == S_ERROR);
  assign tx_start        = tx_start_q;
  assign tx_data         = tx_data_q;
  assign key_valid       = key_valid_q;
  assign key_code        = key_code_q;
  assign retry_exhausted = (retry_q == RETRY_LAST);

  // Map the in-flight command back to the state that retransmits it.
  always_comb begin
    resend_state = S_SEND_RST;
    case (cmd_q)
      CMD_ED:   resend_state = S_SEND_ED;
      CMD_MASK: resend_state = S_SEND_MASK;
      default:  resend_state = S_SEND_RST;
    endcase
  end

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    retry_d       = retry_q;
    timer_d       = timer_q;
    mask_d        = mask_q;
    led_pending_d = led_pending_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    key_valid_d   = 1'b0;
    key_code_d    = key_code_q;

    // Response timer only runs while waiting on the keyboard, saturating at all-ones.
    if ((state_q == S_WAIT_ACK || state_q == S_WAIT_BAT) && timer_q != '1)
      timer_d = timer_q + 32'd1;

    // LED requests seen mid-sequence coalesce into a single pending flag.
    if (led_req && busy)
      led_pending_d = 1'b1;

    // Outside a sequence every received byte is a scan code.
    if (rx_done_tick && !busy) begin
      key_valid_d = 1'b1;
      key_code_d  = rx_data;
    end

    unique case (state_q)
      S_SEND_RST: begin
        tx_start_d = 1'b1;
        tx_data_d  = CMD_RESET;
        cmd_d      = CMD_RST;
        state_d    = S_WAIT_TX;
      end
      S_SEND_ED: begin
        tx_start_d = 1'b1;
        tx_data_d  = CMD_SET_LED;
        cmd_d      = CMD_ED;
        state_d    = S_WAIT_TX;
      end
      S_SEND_MASK: begin
        tx_start_d = 1'b1;
        tx_data_d  = {5'b00000, mask_q};
        cmd_d      = CMD_MASK;
        state_d    = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_done_tick) begin
          timer_d = '0;
          state_d = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        if (rx_done_tick && rx_data == RSP_ACK) begin
          retry_d = '0;
          case (cmd_q)
            CMD_RST: begin
              timer_d = '0;
              state_d = S_WAIT_BAT;
            end
            CMD_ED:  state_d = S_SEND_MASK;
            default: state_d = S_READY;
          endcase
        end else if ((rx_done_tick && rx_data == RSP_RESEND) || timer_q == ACK_LAST) begin
          if (retry_exhausted) begin
            state_d = S_ERROR;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = resend_state;
          end
        end
      end
      S_WAIT_BAT: begin
        if (rx_done_tick && rx_data == RSP_BAT_OK) begin
          state_d = S_READY;
        end else if ((rx_done_tick && rx_data == RSP_BAT_FAIL) || timer_q == BAT_LAST) begin
          if (retry_exhausted) begin
            state_d = S_ERROR;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = S_SEND_RST;
          end
        end
      end
      S_READY: begin
        if (init_req) begin
          state_d = S_SEND_RST;
          if (led_req) led_pending_d = 1'b1;
        end else if (led_req || led_pending_q) begin
          mask_d        = led_mask;
          led_pending_d = 1'b0;
          state_d       = S_SEND_ED;
        end
      end
      S_ERROR: begin
        if (init_req) begin
          retry_d = '0;
          state_d = S_SEND_RST;
        end
      end
      default: state_d = S_SEND_RST;
    endcase
  end

  // State and output registers; reset restarts the keyboard reset sequence.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_SEND_RST;
      cmd_q         <= CMD_RST;
      retry_q       <= '0;
      timer_q       <= '0;
      mask_q        <= '0;
      led_pending_q <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      key_valid_q   <= 1'b0;
      key_code_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      retry_q       <= retry_d;
      timer_q       <= timer_d;
      mask_q        <= mask_d;
      led_pending_q <= led_pending_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
    end
  end

endmodule
